move_seq_ctrl: RTL and testbench

MOVE_SEQ_CTRL -- requirements
Module: move_seq_ctrl

---
 rtl/move_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_move_seq_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/move_seq_ctrl.sv
// move_seq_ctrl: plays back a stored path of 2-bit moves over a
// 2**GRID_W x 2**GRID_W grid. Each move is offered on a valid/ready handshake,
// the position is tracked, and any move that would leave the grid is refused.
// Latency: first move is offered 1 cycle after start; one move per cycle while
// mv_ready is held high. Backpressure: mv_dir/mv_valid hold until mv_ready.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   load, path_in, path_len     capture a packed path (move k at [2k+1:2k])
//   start, abort                begin playback from (0,0) / stop playback
//   mv_valid, mv_ready, mv_dir  move handshake and direction (00 up, 01 right,
//                               10 down, 11 left)
//   pos_x, pos_y, moves_done    current position and accepted move count
//   busy, done, err             in PLAY / FINISH / ERROR
module move_seq_ctrl #(
  parameter int MAX_MOVES = 128,
  parameter int GRID_W    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [2*MAX_MOVES-1:0] path_in,
  input  logic [7:0]             path_len,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   mv_ready,
  output logic                   mv_valid,
  output logic [1:0]             mv_dir,
  output logic [GRID_W-1:0]      pos_x,
  output logic [GRID_W-1:0]      pos_y,
  output logic [7:0]             moves_done,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_PLAY,
    S_FINISH,
    S_ERROR
  } state_t;

  localparam logic [7:0]        MAX_LEN = 8'(MAX_MOVES);
  localparam logic [GRID_W-1:0] XY_MAX  = '1;
  localparam logic [GRID_W-1:0] XY_ONE  = GRID_W'(1);

  state_t                 state;
  state_t                 state_nxt;
  logic [2*MAX_MOVES-1:0] path_buf;
  logic [7:0]             path_cnt;
  logic [7:0]             idx;
  logic [1:0]             cur_dir;
  logic                   in_play;
  logic                   legal;
  logic                   xfer;
  logic                   last_move;
  logic                   load_ok;
  logic                   start_ok;

  // Move selected by the registered index.
  always_comb begin
    cur_dir = 2'b00;
    for (int k = 0; k < MAX_MOVES; k++) begin
      if (idx == 8'(k)) cur_dir = path_buf[2*k +: 2];
    end
  end

  // A move is legal unless it would step off the grid edge.
  always_comb begin
    legal = 1'b1;
    case (cur_dir)
      2'b00:   if (pos_y == '0)     legal = 1'b0;
      2'b01:   if (pos_x == XY_MAX) legal = 1'b0;
      2'b10:   if (pos_y == XY_MAX) legal = 1'b0;
      default: if (pos_x == '0)     legal = 1'b0;
    endcase
  end

  assign in_play   = (state == S_PLAY);
  assign xfer      = in_play && legal && mv_ready;
  assign last_move = (idx == path_cnt - 8'd1);
  assign load_ok   = load && !in_play && (path_len <= MAX_LEN);
  // load takes priority over a simultaneous start.
  assign start_ok  = start && !load && ((state == S_READY) || (state == S_FINISH));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    if (load && !in_play) begin
      state_nxt = (path_len > MAX_LEN) ? S_ERROR : S_READY;
    end else begin
      case (state)
        S_READY, S_FINISH: begin
          if (start) state_nxt = (path_cnt == 8'd0) ? S_FINISH : S_PLAY;
        end
        S_PLAY: begin
          // abort wins over completion/error; a transfer in the same cycle
          // still lands in the datapath below.
          if (abort)                  state_nxt = S_READY;
          else if (!legal)            state_nxt = S_ERROR;
          else if (xfer && last_move) state_nxt = S_FINISH;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Output logic, decoded from the registered state.
  always_comb begin
    busy     = in_play;
    done     = (state == S_FINISH);
    err      = (state == S_ERROR);
    mv_valid = in_play && legal;
    mv_dir   = in_play ? cur_dir : 2'b00;
  end

  // Path storage, index, counters and position.
  always_ff @(posedge clk) begin
    if (rst) begin
      path_cnt   <= 8'd0;
      idx        <= 8'd0;
      moves_done <= 8'd0;
      pos_x      <= '0;
      pos_y      <= '0;
    end else begin
      if (load_ok) begin
        path_buf <= path_in;
        path_cnt <= path_len;
      end
      if (start_ok) begin
        idx        <= 8'd0;
        moves_done <= 8'd0;
        pos_x      <= '0;
        pos_y      <= '0;
      end else if (xfer) begin
        idx        <= idx + 8'd1;
        moves_done <= moves_done + 8'd1;
        case (cur_dir)
          2'b00:   pos_y <= pos_y - XY_ONE;
          2'b01:   pos_x <= pos_x + XY_ONE;
          2'b10:   pos_y <= pos_y + XY_ONE;
          default: pos_x <= pos_x - XY_ONE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_move_seq_ctrl.sv
// Bench for move_seq_ctrl: expected moves (direction plus the position before
// the move) are queued when playback starts and compared as transfers occur.
module tb_move_seq_ctrl;

  localparam int MM = 16;
  localparam int GW = 4;

  logic            clk = 1'b0;
  logic            rst, load, start, abort, mv_ready;
  logic [2*MM-1:0] path_in;
  logic [7:0]      path_len;
  logic            mv_valid;
  logic [1:0]      mv_dir;
  logic [GW-1:0]   pos_x, pos_y;
  logic [7:0]      moves_done;
  logic            busy, done, err;

  move_seq_ctrl #(.MAX_MOVES(MM), .GRID_W(GW)) dut (
    .clk(clk), .rst(rst), .load(load), .path_in(path_in), .path_len(path_len),
    .start(start), .abort(abort), .mv_ready(mv_ready), .mv_valid(mv_valid),
    .mv_dir(mv_dir), .pos_x(pos_x), .pos_y(pos_y), .moves_done(moves_done),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d;
    int x;
    int y;
  } exp_t;

  exp_t            exp_q[$];
  int              n_checks = 0;
  int              n_err    = 0;
  int              xfers    = 0;
  logic [2*MM-1:0] m_path   = '0;
  int              m_len    = 0;
  logic            prev_hold = 1'b0;
  logic [1:0]      prev_dir  = 2'b00;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_path(input logic [2*MM-1:0] p, input int len);
    path_in  = p;
    path_len = 8'(len);
    load     = 1'b1;
    cycle();
    load     = 1'b0;
    if (len <= MM) begin
      m_path = p;
      m_len  = len;
    end
  endtask

  // Walk the model path from the origin, queue every legal move, pulse start.
  task automatic start_play();
    int         x = 0;
    int         y = 0;
    logic [1:0] d;
    exp_t       e;
    for (int k = 0; k < m_len; k++) begin
      d = m_path[2*k +: 2];
      if ((d == 2'b11 && x == 0) || (d == 2'b00 && y == 0) ||
          (d == 2'b01 && x == 2**GW-1) || (d == 2'b10 && y == 2**GW-1)) break;
      e.d = int'(d); e.x = x; e.y = y;
      exp_q.push_back(e);
      case (d)
        2'b00:   y--;
        2'b01:   x++;
        2'b10:   y++;
        default: x--;
      endcase
    end
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_until_end(input int budget);
    int n = 0;
    while (!(done || err) && n < budget) begin
      cycle();
      n++;
    end
    if (!(done || err)) check("timeout", 0, 1);
  endtask

  // Transfer monitor and hold-stability checker, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (prev_hold) begin
        check("hold_vld", int'(mv_valid), 1);
        check("hold_dir", int'(mv_dir), int'(prev_dir));
      end
      if (mv_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_vld", 1, 0);
        end else if (mv_ready) begin
          e = exp_q.pop_front();
          check("xfer_dir", int'(mv_dir), e.d);
          check("xfer_x", int'(pos_x), e.x);
          check("xfer_y", int'(pos_y), e.y);
          xfers++;
        end
      end
    end
    prev_hold = !rst && mv_valid && !mv_ready && !abort;
    prev_dir  = mv_dir;
  end

  initial begin
    int x0;
    rst = 1'b1; load = 1'b0; start = 1'b0; abort = 1'b0; mv_ready = 1'b0;
    path_in = '0; path_len = 8'd0;
    cycle();
    cycle();
    rst = 1'b0;
    check("rst_vld", int'(mv_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_x", int'(pos_x), 0);
    check("rst_y", int'(pos_y), 0);
    check("rst_cnt", int'(moves_done), 0);

    // Basic playback: right, right, down.
    load_path(32'b10_01_01, 3);
    check("ld_busy", int'(busy), 0);
    check("ld_err", int'(err), 0);
    mv_ready = 1'b1;
    start_play();
    check("b_busy", int'(busy), 1);
    check("b_first_vld", int'(mv_valid), 1);
    check("b_first_dir", int'(mv_dir), 1);
    cycle();
    cycle();
    check("b_not_done_yet", int'(done), 0);
    cycle();
    check("b_done", int'(done), 1);
    check("b_x", int'(pos_x), 2);
    check("b_y", int'(pos_y), 1);
    check("b_cnt", int'(moves_done), 3);
    check("b_xfers", xfers, 3);

    // Backpressure: restart from FINISH, 4 idle cycles before each move.
    mv_ready = 1'b0;
    x0 = xfers;
    start_play();
    for (int m = 0; m < 3; m++) begin
      repeat (4) cycle();
      check("bp_vld", int'(mv_valid), 1);
      mv_ready = 1'b1;
      cycle();
      mv_ready = 1'b0;
    end
    check("bp_done", int'(done), 1);
    check("bp_x", int'(pos_x), 2);
    check("bp_y", int'(pos_y), 1);
    check("bp_xfers", xfers - x0, 3);

    // Illegal first move (up at origin).
    mv_ready = 1'b1;
    load_path(32'b00, 1);
    start_play();
    check("il_err_early", int'(err), 0);
    check("il_vld", int'(mv_valid), 0);
    cycle();
    check("il_err", int'(err), 1);
    check("il_x", int'(pos_x), 0);
    check("il_y", int'(pos_y), 0);

    // Empty path, then oversize length.
    load_path('0, 0);
    check("e_left_err", int'(err), 0);
    start_play();
    check("e_done", int'(done), 1);
    check("e_vld", int'(mv_valid), 0);
    load_path('0, MM + 1);
    check("ov_err", int'(err), 1);

    // Abort during the second transfer of five rightward moves.
    load_path({16{2'b01}}, 5);
    start_play();
    cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    exp_q.delete();
    check("ab_busy", int'(busy), 0);
    check("ab_done", int'(done), 0);
    check("ab_err", int'(err), 0);
    check("ab_cnt", int'(moves_done), 2);
    check("ab_x", int'(pos_x), 2);
    check("ab_y", int'(pos_y), 0);
    start_play();
    check("ab_restart_x", int'(pos_x), 0);
    run_until_end(40);
    check("ab_replay_done", int'(done), 1);
    check("ab_replay_x", int'(pos_x), 5);
    check("ab_replay_cnt", int'(moves_done), 5);

    // Reset after three transfers.
    start_play();
    cycle();
    cycle();
    cycle();
    check("rm_pre_cnt", int'(moves_done), 3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    exp_q.delete();
    check("rm_vld", int'(mv_valid), 0);
    check("rm_busy", int'(busy), 0);
    check("rm_done", int'(done), 0);
    check("rm_err", int'(err), 0);
    check("rm_x", int'(pos_x), 0);
    check("rm_cnt", int'(moves_done), 0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    check("rm_start_ign_busy", int'(busy), 0);
    check("rm_start_ign_done", int'(done), 0);

    // Sixteen rights: the last one would leave the grid at x=15.
    load_path({16{2'b01}}, 16);
    start_play();
    run_until_end(60);
    check("edge_err", int'(err), 1);
    check("edge_x", int'(pos_x), 15);
    check("edge_cnt", int'(moves_done), 15);

    check("q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
